// File: rtl/window_sum_pkg.sv
// Shared types and limits for the sliding-window sum sequencer.
// Pure declarations: no latency and no backpressure of its own.
package window_sum_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        STREAM,
        STALL
    } state_t;

    localparam int WINDOW_MIN = 2;
    localparam int WINDOW_MAX = 8;

    function automatic bit window_legal(input int window);
        return (window >= WINDOW_MIN) && (window <= WINDOW_MAX);
    endfunction

endpackage

// File: rtl/window_sum_sequencer_if.sv
// Sample-in / sum-out handshake bundle for window_sum_sequencer.
// Carries no state; master is the producer/consumer side, slave is the sequencer.
interface window_sum_sequencer_if #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 3
);
    localparam int CNT_W = $clog2(WINDOW + 1);

    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic             out_ready;
    logic [CNT_W-1:0] fill_count;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, fill_count
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, fill_count
    );

endinterface

// File: rtl/window_history.sv
// WINDOW-deep sample shift register with a running modulo sum; updates one cycle after shift_en.
// No handshake of its own: the owner gates shift_en, clr wins over shift_en.
module window_history #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] oldest
);

    logic [WIDTH-1:0] hist [WINDOW];
    logic [WIDTH-1:0] sum_q;

    // Unfilled slots hold zero, so the dropped sample is naturally 0 while filling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
            sum_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < WINDOW; i++) hist[i] <= '0;
            sum_q <= '0;
        end else if (shift_en) begin
            hist[0] <= din;
            for (int i = 1; i < WINDOW; i++) hist[i] <= hist[i-1];
            sum_q <= sum_q + din - hist[WINDOW-1];
        end
    end

    assign sum    = sum_q;
    assign oldest = hist[WINDOW-1];

endmodule

// File: rtl/window_sum_sequencer.sv
// Emits the mod-2^WIDTH sum of the last WINDOW accepted samples, 1 cycle after the accept that fills the window.
// One-entry output stage: in_ready drops while a sum is held unpopped, or during clear/reset.
module window_sum_sequencer
    import window_sum_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 3
) (
    input  logic clk,
    input  logic reset,
    window_sum_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WINDOW);

    generate
        if (!window_legal(WINDOW)) begin : g_bad_window
            $error("window_sum_sequencer: WINDOW out of range");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] fill;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [WIDTH-1:0] hist_sum;
    logic [WIDTH-1:0] oldest;
    logic [WIDTH-1:0] sum_next;
    logic [CNT_W-1:0] fill_next;
    logic             accept;
    logic             pop;
    logic             full;

    assign bus.in_ready = !reset && !bus.clear && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = out_valid_q && bus.out_ready;
    assign full         = (state == STREAM) || (state == STALL);
    assign fill_next    = full ? fill : fill + 1'b1;
    assign sum_next     = hist_sum + bus.in_data - oldest;

    window_history #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW)
    ) u_history (
        .clk      (clk),
        .rst      (reset),
        .shift_en (accept),
        .clr      (bus.clear),
        .din      (bus.in_data),
        .sum      (hist_sum),
        .oldest   (oldest)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            fill        <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else if (bus.clear) begin
            state       <= EMPTY;
            fill        <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            // A same-cycle pop and accept just replaces the held sum.
            if (accept) begin
                fill <= fill_next;
                if (fill_next == FULL_CNT) begin
                    out_valid_q <= 1'b1;
                    out_sum_q   <= sum_next;
                end
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                EMPTY:  if (accept) state <= FILL;
                FILL:   if (accept && fill_next == FULL_CNT) state <= STREAM;
                STREAM: if (out_valid_q && !bus.out_ready) state <= STALL;
                STALL:  if (bus.out_ready) state <= STREAM;
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.fill_count = fill;

endmodule
